// File: rtl/ifq_pkg.sv
`default_nettype none
// ==== ifq_pkg : state type and address helpers for the IFQ refill controller | rev 1.0 ====
package ifq_pkg;

  localparam int WORD_BYTES         = 4;
  localparam int WORD_SHIFT         = $clog2(WORD_BYTES);
  localparam int DEF_WORDS_PER_LINE = 4;
  localparam int LINE_OFS_W         = $clog2(DEF_WORDS_PER_LINE);
  localparam int MAX_ADDR_W         = 64;

  typedef logic [MAX_ADDR_W-1:0] addr_max_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    PUSH  = 3'd3,
    FLUSH = 3'd4,
    DRAIN = 3'd5
  } ifq_refill_state_t;

  // Helpers work on a wide container; callers zero-extend in and truncate out.
  function automatic addr_max_t line_base(input addr_max_t addr, input int ofs_w);
    addr_max_t mask;
    mask = {MAX_ADDR_W{1'b1}} << (ofs_w + WORD_SHIFT);
    return addr & mask;
  endfunction

  function automatic addr_max_t word_idx(input addr_max_t addr, input int ofs_w);
    addr_max_t mask;
    mask = ~({MAX_ADDR_W{1'b1}} << ofs_w);
    return (addr >> WORD_SHIFT) & mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ifq_pc_reg.sv
`default_nettype none
// ==== ifq_pc_reg : fetch PC register with branch redirect and line advance | rev 1.0 ====
module ifq_pc_reg
  import ifq_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                OFS_W    = LINE_OFS_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              advance,
  output logic [ADDR_W-1:0] fetch_pc
);

  localparam logic [ADDR_W-1:0] LINE_BYTES = ADDR_W'(WORD_BYTES << OFS_W);
  localparam logic [ADDR_W-1:0] BYTE_MASK  = ADDR_W'(WORD_BYTES - 1);

  logic [ADDR_W-1:0] base;

  assign base = ADDR_W'(line_base(addr_max_t'(fetch_pc), OFS_W));

  // Advancing past the top line wraps to address 0 by plain modular addition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
    end else if (redirect) begin
      fetch_pc <= redirect_pc & ~BYTE_MASK;
    end else if (advance) begin
      fetch_pc <= base + LINE_BYTES;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ifq_refill_ctrl.sv
`default_nettype none
// ==== ifq_refill_ctrl : keeps the IFQ fed from the I-cache, one line request at a time | rev 1.0 ====
module ifq_refill_ctrl
  import ifq_pkg::*;
#(
  parameter int                ADDR_W         = 32,
  parameter int                FIFO_DEPTH     = 16,
  parameter int                WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  parameter logic [ADDR_W-1:0] RESET_PC       = '0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            branch_valid,
  input  logic [ADDR_W-1:0]               branch_target,
  input  logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  input  logic                            cache_dout_valid,
  output logic                            cache_req,
  output logic [ADDR_W-1:0]               cache_addr,
  output logic                            push_fifo,
  output logic [$clog2(WORDS_PER_LINE)-1:0] push_word_sel,
  output logic [ADDR_W-1:0]               push_pc,
  output logic                            flush_fifo,
  output logic                            busy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int OFS_W = $clog2(WORDS_PER_LINE);

  ifq_refill_state_t state, state_next;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] base;
  logic [OFS_W-1:0]  start_idx;
  logic [OFS_W-1:0]  idx;
  logic [OFS_W:0]    need;
  logic [CNT_W-1:0]  free;
  logic              room;
  logic              last;
  logic              outstanding;
  logic              idx_load;
  logic              idx_inc;
  logic              advance;

  ifq_pc_reg #(
    .ADDR_W   (ADDR_W),
    .OFS_W    (OFS_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk         (clk),
    .reset       (reset),
    .redirect    (branch_valid),
    .redirect_pc (branch_target),
    .advance     (advance),
    .fetch_pc    (fetch_pc)
  );

  assign base      = ADDR_W'(line_base(addr_max_t'(fetch_pc), OFS_W));
  assign start_idx = OFS_W'(word_idx(addr_max_t'(fetch_pc), OFS_W));
  assign need      = (OFS_W+1)'(WORDS_PER_LINE) - {1'b0, start_idx};
  assign free      = CNT_W'(FIFO_DEPTH) - fifo_count;
  assign room      = int'(free) >= int'(need);
  assign last      = (idx == OFS_W'(WORDS_PER_LINE - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A response can only follow a request, so any valid retires the single outstanding one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding <= 1'b0;
    end else if (state == REQ) begin
      outstanding <= 1'b1;
    end else if (cache_dout_valid) begin
      outstanding <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx <= '0;
    end else if (idx_load) begin
      idx <= start_idx;
    end else if (idx_inc) begin
      idx <= idx + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    cache_req  = 1'b0;
    push_fifo  = 1'b0;
    flush_fifo = 1'b0;
    idx_load   = 1'b0;
    idx_inc    = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        if (room) state_next = REQ;
      end
      REQ: begin
        cache_req  = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (cache_dout_valid) begin
          idx_load   = 1'b1;
          state_next = PUSH;
        end
      end
      PUSH: begin
        push_fifo = 1'b1;
        if (last) begin
          advance    = 1'b1;
          state_next = IDLE;
        end else begin
          idx_inc = 1'b1;
        end
      end
      // A response landing in the flush cycle itself already settles the request.
      FLUSH: begin
        flush_fifo = 1'b1;
        state_next = (outstanding && !cache_dout_valid) ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (cache_dout_valid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (branch_valid) begin
      state_next = FLUSH;
      push_fifo  = 1'b0;
      advance    = 1'b0;
      idx_load   = 1'b0;
      idx_inc    = 1'b0;
    end
  end

  assign cache_addr    = base;
  assign push_word_sel = push_fifo ? idx : '0;
  assign push_pc       = push_fifo ? (base + (ADDR_W'(idx) << WORD_SHIFT)) : '0;
  assign busy          = (state != IDLE);

endmodule
`default_nettype wire
